dvi_pattern_generator: RTL and testbench



---
 rtl/dvi_pkg.sv | 38 +++
 rtl/dvi_if.sv | 27 ++
 rtl/dvi_box_mover.sv | 53 +++++
 rtl/dvi_pattern_generator.sv | 123 ++++++++++++
 tb/tb_dvi_pattern_generator.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI test-pattern pixel source.
package dvi_pkg;

  localparam logic [2:0] MODE_BARS  = 3'd0;
  localparam logic [2:0] MODE_GRAD  = 3'd1;
  localparam logic [2:0] MODE_CHECK = 3'd2;
  localparam logic [2:0] MODE_BOX   = 3'd3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam rgb888_t BLACK  = 24'h000000;
  localparam rgb888_t WHITE  = 24'hFFFFFF;
  localparam rgb888_t RED    = 24'hFF0000;
  localparam rgb888_t BOX_BG = 24'h000040;

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  // One pipeline stage: pixel data travels together with its sync/enable.
  typedef struct packed {
    rgb888_t rgb;
    logic    h_sync;
    logic    v_sync;
    logic    de;
  } pipe_t;

  function automatic rgb888_t bar_colour(input logic [2:0] idx);
    return '{r: {8{idx[2]}}, g: {8{idx[1]}}, b: {8{idx[0]}}};
  endfunction

  function automatic rgb888_t solid_colour(input logic [2:0] sel);
    return '{r: {8{sel[0]}}, g: 8'hFF, b: {8{sel[1]}}};
  endfunction

endpackage

// File: rtl/dvi_if.sv
// Raster timing in, pixel data plus delay-matched syncs out.
interface dvi_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  logic [X_W-1:0] pixel_x;
  logic [Y_W-1:0] pixel_y;
  logic           h_sync;
  logic           v_sync;
  logic           dataenable;
  logic [7:0]     red;
  logic [7:0]     green;
  logic [7:0]     blue;
  logic           h_sync_out;
  logic           v_sync_out;
  logic           de_out;

  modport master (
    output pixel_x, pixel_y, h_sync, v_sync, dataenable,
    input  red, green, blue, h_sync_out, v_sync_out, de_out
  );

  modport slave (
    input  pixel_x, pixel_y, h_sync, v_sync, dataenable,
    output red, green, blue, h_sync_out, v_sync_out, de_out
  );
endinterface

// File: rtl/dvi_box_mover.sv
// One axis of the bouncing box: position/direction stepped once per frame,
// clamped against the far edge and the origin.
module dvi_box_mover
  import dvi_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 64,
  parameter int STEP  = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step_en,
  output logic [W-1:0] pos
);

  dir_e         dir, dir_nxt;
  logic [W-1:0] pos_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
      dir <= DIR_POS;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

  // NOTE: hold values are assigned first so every path drives every output (no latch).
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (step_en) begin
      if (dir == DIR_POS) begin
        if (({1'b0, pos} + (W+1)'(STEP + SIZE)) > (W+1)'(LIMIT)) begin
          pos_nxt = W'(LIMIT - SIZE);
          dir_nxt = DIR_NEG;
        end else begin
          pos_nxt = pos + W'(STEP);
        end
      end else begin
        if (pos < W'(STEP)) begin
          pos_nxt = '0;
          dir_nxt = DIR_POS;
        end else begin
          pos_nxt = pos - W'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/dvi_pattern_generator.sv
// Test-pattern pixel source feeding the TMDS encoders; 2-cycle fixed latency.
// Define DVI_PATTERN_BORDER_EN to overlay a 1-pixel white frame border.
module dvi_pattern_generator
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int BOX_STEP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  dvi_if.slave       vid
);

  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = $clog2(BAR_W);

  logic              vs_prev, de_prev, frame_evt, de_rise;
  logic [2:0]        active_mode;
  logic [7:0]        frame_cnt;
  logic [X_W-1:0]    box_x;
  logic [Y_W-1:0]    box_y;
  logic [BAR_CW-1:0] bar_cnt, cur_cnt;
  logic [2:0]        bar_idx, cur_bar;
  logic [7:0]        grad_lvl;
  logic              in_box;
  rgb888_t           pix;
  pipe_t             s1, s2;

  assign frame_evt = vid.v_sync & ~vs_prev;
  assign de_rise   = vid.dataenable & ~de_prev;
  assign cur_cnt   = de_rise ? '0 : bar_cnt;
  assign cur_bar   = de_rise ? '0 : bar_idx;
  assign grad_lvl  = vid.pixel_x[7:0] + frame_cnt;
  assign in_box    = (vid.pixel_x >= box_x) &&
                     ({1'b0, vid.pixel_x} < ({1'b0, box_x} + (X_W+1)'(BOX_SIZE))) &&
                     (vid.pixel_y >= box_y) &&
                     ({1'b0, vid.pixel_y} < ({1'b0, box_y} + (Y_W+1)'(BOX_SIZE)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev     <= 1'b0;
      de_prev     <= 1'b0;
      active_mode <= MODE_BARS;
      frame_cnt   <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
    end else begin
      vs_prev <= vid.v_sync;
      de_prev <= vid.dataenable;
      if (frame_evt) begin
        active_mode <= mode;
        frame_cnt   <= frame_cnt + 8'd1;
      end
      if (vid.dataenable) begin
        if (cur_cnt == BAR_CW'(BAR_W - 1)) begin
          bar_cnt <= '0;
          bar_idx <= cur_bar + 3'd1;
        end else begin
          bar_cnt <= cur_cnt + BAR_CW'(1);
          bar_idx <= cur_bar;
        end
      end
    end
  end

  dvi_box_mover #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP), .W(X_W)) u_box_x (
    .clk     (clk),
    .reset   (reset),
    .step_en (frame_evt),
    .pos     (box_x)
  );

  dvi_box_mover #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP), .W(Y_W)) u_box_y (
    .clk     (clk),
    .reset   (reset),
    .step_en (frame_evt),
    .pos     (box_y)
  );

  always_comb begin
    pix = BLACK;
    case (active_mode)
      MODE_BARS:  pix = bar_colour(cur_bar);
      MODE_GRAD:  pix = '{r: grad_lvl, g: grad_lvl, b: grad_lvl};
      MODE_CHECK: pix = (vid.pixel_x[CHECK_LOG2] ^ vid.pixel_y[CHECK_LOG2]) ? WHITE : BLACK;
      MODE_BOX:   pix = in_box ? RED : BOX_BG;
      default:    pix = solid_colour(active_mode);
    endcase
`ifdef DVI_PATTERN_BORDER_EN
    if (vid.pixel_x == '0 || vid.pixel_x == X_W'(H_ACTIVE - 1) ||
        vid.pixel_y == '0 || vid.pixel_y == Y_W'(V_ACTIVE - 1))
      pix = WHITE;
`endif
    // Out-of-raster coordinates with DE high mean a timing fault upstream.
    if (vid.pixel_x >= X_W'(H_ACTIVE) || vid.pixel_y >= Y_W'(V_ACTIVE))
      pix = BLACK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= '{rgb: pix, h_sync: vid.h_sync, v_sync: vid.v_sync, de: vid.dataenable};
      s2 <= '{rgb: s1.de ? s1.rgb : BLACK, h_sync: s1.h_sync, v_sync: s1.v_sync, de: s1.de};
    end
  end

  assign vid.red        = s2.rgb.r;
  assign vid.green      = s2.rgb.g;
  assign vid.blue       = s2.rgb.b;
  assign vid.h_sync_out = s2.h_sync;
  assign vid.v_sync_out = s2.v_sync;
  assign vid.de_out     = s2.de;

endmodule

// File: tb/tb_dvi_pattern_generator.sv
// Scoreboard bench for dvi_pattern_generator: a behavioural pixel model queues
// the expected output per driven cycle; entries are compared two cycles later.
module tb_dvi_pattern_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode = 3'd0;

  dvi_if #(.X_W(11), .Y_W(10)) vid ();

  dvi_pattern_generator dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .vid   (vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    bit          chk;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: updated at each clock edge from the sampled inputs.
  int         m_frames;
  logic [2:0] m_mode;
  bit         m_vs_prev, m_de_prev;
  int         m_col_next;

  // Box position after n frame events, as a closed-form triangle wave that
  // rests one frame at each end while the direction flips.
  function automatic int box_pos(input int n, input int maxp);
    int u, p, k;
    u = maxp / 4;
    p = 2 * u + 2;
    k = n % p;
    if (k <= u) return 4 * k;
    return maxp - 4 * (k - u - 1);
  endfunction

  function automatic logic [23:0] model_rgb(input int x, input int y, input bit de, input int col);
    logic [23:0] c;
    logic [2:0]  b;
    int          v, bx, by;
    if (!de) return 24'h0;
    if (x >= 640 || y >= 480) return 24'h0;
`ifdef DVI_PATTERN_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 24'hFFFFFF;
`endif
    case (m_mode)
      3'd0: begin
        b = 3'((col / 80) % 8);
        c = {(b[2] ? 8'hFF : 8'h00), (b[1] ? 8'hFF : 8'h00), (b[0] ? 8'hFF : 8'h00)};
      end
      3'd1: begin
        v = (x + m_frames) % 256;
        c = {3{8'(v)}};
      end
      3'd2: c = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      3'd3: begin
        bx = box_pos(m_frames, 576);
        by = box_pos(m_frames, 416);
        c = (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFF0000 : 24'h000040;
      end
      default: c = {(m_mode[0] ? 8'hFF : 8'h00), 8'hFF, (m_mode[1] ? 8'hFF : 8'h00)};
    endcase
    return c;
  endfunction

  // One pixel clock: drive, queue the expectation, advance the model, and
  // compare the entry whose result is now on the outputs.
  task automatic step(input int x, input int y, input bit hs, input bit vs,
                      input bit de, input bit chk, input string tag);
    exp_t e, got;
    int   cur_col;
    vid.pixel_x    = 11'(x);
    vid.pixel_y    = 10'(y);
    vid.h_sync     = hs;
    vid.v_sync     = vs;
    vid.dataenable = de;
    cur_col = (de && !m_de_prev) ? 0 : m_col_next;
    e.rgb = model_rgb(x, y, de, cur_col);
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    e.chk = chk && !reset;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_frames = 0; m_mode = 3'd0; m_vs_prev = 0; m_de_prev = 0; m_col_next = 0;
    end else begin
      if (vs && !m_vs_prev) begin
        m_mode   = mode;
        m_frames = m_frames + 1;
      end
      m_vs_prev = vs;
      m_de_prev = de;
      if (de) m_col_next = cur_col + 1;
    end
    @(negedge clk);
    if (sb.size() >= 2) begin
      got = sb.pop_front();
      if (got.chk) begin
        n_cmp++;
        if ({vid.red, vid.green, vid.blue, vid.h_sync_out, vid.v_sync_out, vid.de_out} !==
            {got.rgb, got.hs, got.vs, got.de}) begin
          n_err++;
          $display("FAIL %s: got rgb=%02h%02h%02h hs=%b vs=%b de=%b, want rgb=%06h hs=%b vs=%b de=%b",
                   got.tag, vid.red, vid.green, vid.blue, vid.h_sync_out, vid.v_sync_out,
                   vid.de_out, got.rgb, got.hs, got.vs, got.de);
        end
      end
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, tag);
  endtask

  task automatic vsync_pulse(input string tag);
    idle(2, tag);
    step(0, 0, 0, 1, 0, 1, tag);
    step(0, 0, 0, 1, 0, 1, tag);
    idle(2, tag);
  endtask

  task automatic line(input int y, input int x0, input int n, input string tag);
    step(0, y, 1, 0, 0, 1, tag);
    step(0, y, 1, 0, 0, 1, tag);
    step(0, y, 0, 0, 0, 1, tag);
    for (int i = 0; i < n; i++) step(x0 + i, y, 0, 0, 1, 1, tag);
    idle(2, tag);
  endtask

  task automatic pixel(input int x, input int y, input string tag);
    step(x, y, 0, 0, 1, 1, tag);
    step(0, y, 0, 0, 0, 1, tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode  = 3'd5;
    for (int i = 0; i < 3; i++) step(5, 5, 1, 1, 1, 0, "reset");
    n_cmp++;
    if ({vid.red, vid.green, vid.blue, vid.h_sync_out, vid.v_sync_out, vid.de_out} !== 27'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %02h%02h%02h %b%b%b, want all zero",
               vid.red, vid.green, vid.blue, vid.h_sync_out, vid.v_sync_out, vid.de_out);
    end
    reset = 1'b0;
    idle(3, "post_reset");
  endtask

  task automatic test_frame_count();
    mode = 3'd1;
    vsync_pulse("grad_vs1");
    line(10, 0, 20, "grad_f1");
    line(11, 250, 10, "grad_wrap");
    vsync_pulse("grad_vs2");
    line(12, 0, 8, "grad_f2");
  endtask

  task automatic test_bars();
    mode = 3'd0;
    vsync_pulse("bars_vs");
    line(5, 0, 640, "bars_l5");
    line(6, 0, 640, "bars_l6");
  endtask

  task automatic test_checker();
    mode = 3'd2;
    vsync_pulse("check_vs");
    pixel(31, 0, "check_31_0");
    pixel(32, 0, "check_32_0");
    pixel(32, 32, "check_32_32");
    pixel(0, 32, "check_0_32");
    line(40, 0, 70, "check_l40");
  endtask

  task automatic test_box();
    int bx, by;
    mode = 3'd3;
    for (int f = 0; f < 200; f++) begin
      vsync_pulse("box_vs");
      bx = box_pos(m_frames, 576);
      by = box_pos(m_frames, 416);
      if (bx > 0) pixel(bx - 1, by + 1, "box_left_out");
      pixel(bx, by + 1, "box_left_in");
      pixel(bx + 63, by + 1, "box_right_in");
      pixel(bx + 64, by + 1, "box_right_out");
      if (by > 0) pixel(bx + 1, by - 1, "box_top_out");
      pixel(bx + 1, by + 63, "box_bot_in");
      pixel(bx + 1, by + 64, "box_bot_out");
    end
  endtask

  task automatic test_mode_switch();
    mode = 3'd0;
    vsync_pulse("sw_vs0");
    step(0, 50, 1, 0, 0, 1, "sw_hs");
    step(0, 50, 0, 0, 0, 1, "sw_hs");
    for (int i = 0; i < 320; i++) step(i, 50, 0, 0, 1, 1, "sw_first_half");
    mode = 3'd2;
    for (int i = 320; i < 640; i++) step(i, 50, 0, 0, 1, 1, "sw_second_half");
    idle(2, "sw_idle");
    line(51, 0, 640, "sw_same_frame");
    vsync_pulse("sw_vs1");
    line(33, 0, 640, "sw_next_frame");
  endtask

  task automatic test_solid_and_fault();
    for (int m = 4; m < 8; m++) begin
      mode = 3'(m);
      vsync_pulse("solid_vs");
      line(100, 100, 4, "solid");
    end
    pixel(700, 100, "fault_x");
    pixel(100, 500, "fault_y");
    pixel(640, 479, "fault_x_edge");
  endtask

  task automatic test_border();
    mode = 3'd3;
    vsync_pulse("border_vs");
    pixel(0, 200, "border_left");
    pixel(639, 200, "border_right");
    pixel(300, 0, "border_top");
    pixel(300, 479, "border_bottom");
    pixel(1, 200, "border_inner");
  endtask

  initial begin
    m_frames = 0; m_mode = 3'd0; m_vs_prev = 0; m_de_prev = 0; m_col_next = 0;
    vid.pixel_x = '0;
    vid.pixel_y = '0;
    vid.h_sync = 1'b0;
    vid.v_sync = 1'b0;
    vid.dataenable = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_count();
    test_bars();
    test_checker();
    test_box();
    test_mode_switch();
    test_solid_and_fault();
    test_border();
    idle(4, "drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
